// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Multi-cycle wrapper between ID/EX and the HI/LO register pair.
// - Latches the operands and feeds them to a combinational multiplier and
//   divider.
// - Waits a fixed number of cycles so their long paths can settle. These paths
//   start at a_q/b_q/op_q and end at hi_q/lo_q, and are declared multicycle.
// - Writes the product, or the quotient and remainder, into HI/LO.
// - Handles MTHI/MTLO directly from IDLE. Those writes are visible the next
//   cycle and raise neither busy nor done.
//
// Handshake: start is sampled on a rising edge only while busy=0. A start seen
// while busy=1 (any op) is dropped entirely, so the requester must hold it
// until busy falls. The done cycle is already IDLE, which allows back-to-back
// operations.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   request, sampled when busy=0
//   op         in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                       100 MTHI, 101 MTLO, 11x no-op
//   a          in   32  rs operand (dividend / multiplicand / MTHI/MTLO data)
//   b          in   32  rt operand (divisor / multiplier)
//   busy       out  1   mul/div in flight
//   done       out  1   one-cycle pulse after HI/LO update by mul/div
//   dbz        out  1   one-cycle pulse with done when the divisor was zero
//   hi         out  32  HI register
//   lo         out  32  LO register
//   state_dbg  out  1   FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        state_dbg
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [5:0] MUL_CNT = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_CNT = 6'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;          // op[1]=div, op[0]=unsigned
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic        latch_en;

    // ------------------------------------------------------------------
    // Combinational arithmetic on the latched operands (multicycle paths)
    // ------------------------------------------------------------------
    logic        signed_op;
    logic        is_div;
    logic [63:0] mul_a_ext, mul_b_ext, product;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] uquot, urem;
    logic [31:0] quot, rem;
    logic        div_zero;

    assign signed_op = ~op_q[0];
    assign is_div    = op_q[1];

    // Extending by the sign bit makes the low 64 bits of the 64x64 product
    // the correct signed or unsigned 32x32 result.
    assign mul_a_ext = {{32{signed_op & a_q[31]}}, a_q};
    assign mul_b_ext = {{32{signed_op & b_q[31]}}, b_q};
    assign product   = mul_a_ext * mul_b_ext;

    // Signed division is done on magnitudes, and the signs are then restored.
    // The quotient is truncated toward zero and the remainder takes the
    // dividend's sign. For 0x80000000 / -1, the magnitude 0x80000000
    // re-negates to itself, which gives the wrapped result without a trap.
    assign a_neg    = signed_op & a_q[31];
    assign b_neg    = signed_op & b_q[31];
    assign a_mag    = a_neg ? (~a_q + 32'd1) : a_q;
    assign b_mag    = b_neg ? (~b_q + 32'd1) : b_q;
    assign div_zero = (b_q == 32'd0);
    assign uquot    = div_zero ? 32'd0 : (a_mag / b_mag);
    assign urem     = div_zero ? 32'd0 : (a_mag % b_mag);
    assign quot     = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
    assign rem      = a_neg ? (~urem + 32'd1) : urem;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !op[2]) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == 6'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001: begin
                            latch_en = 1'b1;
                            cnt_d    = MUL_CNT;
                        end
                        3'b010, 3'b011: begin
                            latch_en = 1'b1;
                            cnt_d    = DIV_CNT;
                        end
                        3'b100:  hi_d = a;
                        3'b101:  lo_d = a;
                        default: ;  // 11x: no-op
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == 6'd1) begin
                    cnt_d  = 6'd0;
                    done_d = 1'b1;
                    if (is_div) begin
                        if (div_zero) begin
                            dbz_d = 1'b1;  // HI/LO left untouched
                        end else begin
                            hi_d = rem;
                            lo_d = quot;
                        end
                    end else begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 6'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            op_q   <= 2'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
            if (latch_en) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op[1:0];
            end
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = (state_q == S_RUN);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//
// Directed bench for hilo_muldiv_unit, using the default MUL_CYCLES=4 and
// DIV_CYCLES=8. Inputs are driven 1 ns after the rising edge, and outputs are
// sampled at the same point. Expected {hi,lo} values for mul/div are
// hand-computed and queued in exp_q when an operation is issued. Each value is
// popped when that operation completes.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'b000;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        state_dbg;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    hilo_muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge. Afterwards, scramble a/b so that only
    // the latched copies can produce the right answer.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom_range(32'hFFFF_FFFF, 0);
        b     = $urandom_range(32'hFFFF_FFFF, 0);
    endtask

    task automatic start_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [63:0] exp_hilo);
        exp_q.push_back(exp_hilo);
        issue(o, x, y);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_state"}, 64'(state_dbg), 64'd1);
    endtask

    task automatic finish_op(input string tag, input int n, input logic exp_dbz);
        int cycles;
        logic [63:0] exp_hilo;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!done && cycles < 100);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_latency"}, 64'(cycles), 64'(n));
        check({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
        exp_hilo = exp_q.pop_front();
        check({tag, "_hilo"}, {hi, lo}, exp_hilo);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic pulse_end(input string tag);
        tick();
        check({tag, "_done_1cyc"}, 64'(done), 64'd0);
        check({tag, "_dbz_1cyc"}, 64'(dbz), 64'd0);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    // ---------------- safety timeout ----------------
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ndone;

        // Reset state
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1. MULT -3 * 7 = -21
        start_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        finish_op("mult_neg", 4, 1'b0);
        pulse_end("mult_neg");

        // 2. MULTU and MULT of all-ones
        start_op("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        finish_op("multu_ff", 4, 1'b0);
        start_op("mult_ff", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0, 32'h1});
        finish_op("mult_ff", 4, 1'b0);

        // 3. Division: signs, unsigned, overflow corner
        start_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        finish_op("div_neg", 8, 1'b0);
        pulse_end("div_neg");
        start_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD});
        finish_op("div_negb", 8, 1'b0);
        start_op("divu", OP_DIVU, 32'd7, 32'd2, {32'd1, 32'd3});
        finish_op("divu", 8, 1'b0);
        start_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        finish_op("div_ovf", 8, 1'b0);

        // No-op leaves everything alone
        issue(OP_NOP, 32'h1234, 32'h5678);
        check("nop_busy", 64'(busy), 64'd0);
        check("nop_hilo", {hi, lo}, {32'h0, 32'h8000_0000});
        tick();
        check("nop_done", 64'(done), 64'd0);

        // 4. MTHI/MTLO preload, then divide by zero
        issue(OP_MTHI, 32'h11, 32'd0);
        check("mthi_hi", 64'(hi), 64'h11);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        check("mtlo_lo", 64'(lo), 64'h22);
        check("mtlo_hi", 64'(hi), 64'h11);
        start_op("dbz", OP_DIV, 32'd5, 32'd0, {32'h11, 32'h22});
        finish_op("dbz", 8, 1'b1);
        pulse_end("dbz");

        // 5. Starts during RUN are ignored, and a back-to-back start is taken
        start_op("div_ign", OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14});
        op    = OP_MTHI;
        a     = 32'hAAAA;
        start = 1'b1;
        tick();
        op = OP_MULT;
        a  = 32'd3;
        b  = 32'd3;
        tick();
        start = 1'b0;
        check("div_ign_hold_hi", 64'(hi), 64'h11);
        check("div_ign_still_busy", 64'(busy), 64'd1);
        finish_op("div_ign", 6, 1'b0);
        // Issue in the done cycle, with no extra tick
        start_op("b2b", OP_MULT, 32'h0001_0000, 32'h0001_0000, {32'h1, 32'h0});
        finish_op("b2b", 4, 1'b0);
        count_dones(10, ndone);
        check("b2b_no_extra_done", 64'(ndone), 64'd0);
        check("b2b_hilo_stable", {hi, lo}, {32'h1, 32'h0});

        // 6. Reset while RUN is active
        issue(OP_MULT, 32'd5, 32'd5);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        check("rstmid_hilo", {hi, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        count_dones(12, ndone);
        check("rstmid_no_done", 64'(ndone), 64'd0);
        check("rstmid_idle", 64'(busy), 64'd0);
        check("rstmid_hilo_after", {hi, lo}, 64'd0);
        start_op("post_rst", OP_MULT, 32'd2, 32'd3, {32'd0, 32'd6});
        finish_op("post_rst", 4, 1'b0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
